// File: rtl/wb_to_obi_pipe.sv
// wb_to_obi_pipe: Wishbone-B4 pipelined slave to OBI master bridge.
//
// One OBI request is issued per Wishbone strobe. No stall cycles are inserted while
// gnt_i is high. Up to MAX_OUT transactions may be outstanding at once. Reads and
// writes both complete on rvalid_i. If wbs_cyc_i drops while responses are still
// pending, the bridge enters a drain state. There it absorbs the remaining responses
// and does not acknowledge them.
//
// Optional feature macro: WB_TO_OBI_ERR_EN adds err_i / wbs_err_o error signalling.
//
// Ports:
//   clk_i, rst_ni             clock (rising edge), asynchronous active-low reset
//   wbs_cyc_i, wbs_stb_i      Wishbone cycle / strobe
//   wbs_we_i, wbs_sel_i       Wishbone write enable / byte select
//   wbs_adr_i, wbs_dat_i      Wishbone address / write data
//   wbs_ack_o, wbs_stall_o    Wishbone acknowledge (registered) / stall (combinational)
//   wbs_dat_o                 Wishbone read data (registered)
//   wbs_err_o                 Wishbone error (registered, WB_TO_OBI_ERR_EN only)
//   req_o, gnt_i              OBI request / grant
//   addr_o, we_o, be_o        OBI address / write enable / byte enable
//   wdata_o                   OBI write data
//   rvalid_i, rdata_i         OBI response valid / read data
//   err_i                     OBI error (WB_TO_OBI_ERR_EN only)
module wb_to_obi_pipe #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_OUT = 4,
  localparam int unsigned SEL_W  = DATA_W / 8,
  localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [SEL_W-1:0]  wbs_sel_i,
  input  logic [ADDR_W-1:0] wbs_adr_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  output logic              wbs_ack_o,
  output logic              wbs_stall_o,
  output logic [DATA_W-1:0] wbs_dat_o,
`ifdef WB_TO_OBI_ERR_EN
  output logic              wbs_err_o,
`endif
  output logic              req_o,
  input  logic              gnt_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              we_o,
  output logic [SEL_W-1:0]  be_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic              rvalid_i,
`ifdef WB_TO_OBI_ERR_EN
  input  logic              err_i,
`endif
  input  logic [DATA_W-1:0] rdata_i
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUT);

  typedef enum logic [0:0] {StActive, StDrain} state_e;

  state_e             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic               r_ack;
  logic [DATA_W-1:0]  r_dat;
  logic               w_can_issue;
  logic               w_inc;
  logic               w_dec;
  logic               w_resp_err;

`ifdef WB_TO_OBI_ERR_EN
  logic r_err;
  assign w_resp_err = err_i;
  assign wbs_err_o  = r_err;
`else
  assign w_resp_err = 1'b0;
`endif

  // Full is judged on the registered count, so a response freeing a slot only
  // re-enables issue from the following cycle.
  assign w_can_issue = wbs_cyc_i & wbs_stb_i & (r_state == StActive) & (r_cnt < MaxCnt);
  assign w_inc       = w_can_issue & gnt_i;
  // Responses arriving with nothing outstanding (e.g. stragglers after reset) are dropped.
  assign w_dec       = rvalid_i & (r_cnt != '0);

  assign req_o       = w_can_issue;
  assign wbs_stall_o = !w_inc;
  assign addr_o      = wbs_adr_i;
  assign we_o        = wbs_we_i;
  assign be_o        = wbs_sel_i;
  assign wdata_o     = wbs_dat_i;
  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dat;

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_inc && !w_dec) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end else if (!w_inc && w_dec) begin
      w_cnt_next = r_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StActive: if (!wbs_cyc_i && (w_cnt_next != '0)) w_state_next = StDrain;
      StDrain:  if (w_cnt_next == '0) w_state_next = StActive;
      default:  w_state_next = StActive;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StActive;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      // Responses consumed while draining are not reported to the master.
      r_ack   <= w_dec & (r_state == StActive) & !w_resp_err;
      if (rvalid_i) r_dat <= rdata_i;
    end
  end

`ifdef WB_TO_OBI_ERR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_dec & (r_state == StActive) & w_resp_err;
    end
  end
`endif

endmodule

// File: tb/tb_wb_to_obi_pipe.sv
// Self-checking bench for wb_to_obi_pipe (default parameters, MAX_OUT = 4).
// Inputs are driven on the falling edge and outputs are sampled 1 ns later.
// Each vector's expected ack/dat is therefore the value registered at the previous rising edge.
module tb_wb_to_obi_pipe;

  typedef struct {
    logic        cyc, stb, we;
    logic [31:0] adr, wdat;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        err;
    logic        exp_req, exp_stall, exp_ack;
    logic [31:0] exp_dat;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 0, stb = 0, we = 0, gnt = 0, rvalid = 0, err = 0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, wdat = '0, rdata = '0;
  logic        ack, stall, req, we_o;
  logic [31:0] dat_o, addr_o, wdata_o;
  logic [3:0]  be_o;
  logic        wb_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_to_obi_pipe dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack),
    .wbs_stall_o(stall),
    .wbs_dat_o  (dat_o),
`ifdef WB_TO_OBI_ERR_EN
    .wbs_err_o  (wb_err),
`endif
    .req_o      (req),
    .gnt_i      (gnt),
    .addr_o     (addr_o),
    .we_o       (we_o),
    .be_o       (be_o),
    .wdata_o    (wdata_o),
    .rvalid_i   (rvalid),
`ifdef WB_TO_OBI_ERR_EN
    .err_i      (err),
`endif
    .rdata_i    (rdata)
  );

`ifndef WB_TO_OBI_ERR_EN
  assign wb_err = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  function automatic vec_t mk(input logic c, input logic s, input logic w,
                              input logic [31:0] a, input logic [31:0] d, input logic g,
                              input logic r, input logic [31:0] rd, input logic xreq,
                              input logic xstall, input logic xack, input logic [31:0] xdat);
    vec_t v;
    v.cyc = c; v.stb = s; v.we = w; v.adr = a; v.wdat = d; v.gnt = g;
    v.rv = r; v.rdata = rd; v.err = 1'b0;
    v.exp_req = xreq; v.exp_stall = xstall; v.exp_ack = xack; v.exp_dat = xdat;
    v.exp_err = 1'b0;
    return v;
  endfunction

  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    cyc = v.cyc; stb = v.stb; we = v.we; adr = v.adr; wdat = v.wdat;
    sel = v.wdat[3:0]; gnt = v.gnt; rvalid = v.rv; rdata = v.rdata; err = v.err;
    #1;
    chk({tag, ".req"},   {31'd0, req},   {31'd0, v.exp_req});
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, v.exp_stall});
    chk({tag, ".ack"},   {31'd0, ack},   {31'd0, v.exp_ack});
    chk({tag, ".dat"},   dat_o,          v.exp_dat);
    chk({tag, ".pass"},  {addr_o ^ wdata_o, 27'd0, we_o, be_o},
        {v.adr ^ v.wdat, 27'd0, v.we, v.wdat[3:0]});
`ifdef WB_TO_OBI_ERR_EN
    chk({tag, ".err"},   {31'd0, wb_err}, {31'd0, v.exp_err});
`endif
  endtask

  vec_t tbl[32];
  vec_t v;

  initial begin
    //           cyc stb we adr       wdat      gnt rv rdata       req stl ack dat
    tbl[0]  = mk(1, 1, 0, 32'h100, 32'h0,   1, 0, 32'h0,        1, 0, 0, 32'h0);
    tbl[1]  = mk(0, 0, 0, 32'h0,   32'h0,   1, 1, 32'hDEADBEEF, 0, 1, 0, 32'h0);
    tbl[2]  = mk(0, 0, 0, 32'h0,   32'h0,   1, 0, 32'h0,        0, 1, 1, 32'hDEADBEEF);
    // stray response with nothing outstanding
    tbl[3]  = mk(0, 0, 0, 32'h0,   32'h0,   1, 1, 32'hDEADBEEF, 0, 1, 0, 32'hDEADBEEF);
    tbl[4]  = mk(0, 0, 0, 32'h0,   32'h0,   1, 0, 32'h0,        0, 1, 0, 32'hDEADBEEF);
    // back-to-back writes up to full
    tbl[5]  = mk(1, 1, 1, 32'h200, 32'hA0,  1, 0, 32'h0,        1, 0, 0, 32'hDEADBEEF);
    tbl[6]  = mk(1, 1, 1, 32'h204, 32'hA1,  1, 0, 32'h0,        1, 0, 0, 32'hDEADBEEF);
    tbl[7]  = mk(1, 1, 1, 32'h208, 32'hA2,  1, 0, 32'h0,        1, 0, 0, 32'hDEADBEEF);
    tbl[8]  = mk(1, 1, 1, 32'h20C, 32'hA3,  1, 0, 32'h0,        1, 0, 0, 32'hDEADBEEF);
    tbl[9]  = mk(1, 1, 1, 32'h210, 32'hA4,  1, 0, 32'h0,        0, 1, 0, 32'hDEADBEEF);
    tbl[10] = mk(1, 1, 1, 32'h210, 32'hA4,  1, 1, 32'h0,        0, 1, 0, 32'hDEADBEEF);
    tbl[11] = mk(1, 1, 1, 32'h210, 32'hA4,  1, 0, 32'h0,        1, 0, 1, 32'h0);
    tbl[12] = mk(1, 1, 1, 32'h214, 32'hA5,  1, 1, 32'h0,        0, 1, 0, 32'h0);
    tbl[13] = mk(1, 0, 1, 32'h214, 32'hA5,  1, 1, 32'h0,        0, 1, 1, 32'h0);
    // cnt = 2: grant and response together, count holds
    tbl[14] = mk(1, 1, 1, 32'h214, 32'hA5,  1, 1, 32'h22,       1, 0, 1, 32'h0);
    tbl[15] = mk(1, 0, 0, 32'h0,   32'h0,   1, 0, 32'h0,        0, 1, 1, 32'h22);
    tbl[16] = mk(1, 0, 0, 32'h0,   32'h0,   1, 1, 32'h33,       0, 1, 0, 32'h22);
    tbl[17] = mk(1, 0, 0, 32'h0,   32'h0,   1, 1, 32'h44,       0, 1, 1, 32'h33);
    tbl[18] = mk(1, 0, 0, 32'h0,   32'h0,   1, 1, 32'h44,       0, 1, 1, 32'h44);
    tbl[19] = mk(1, 0, 0, 32'h0,   32'h0,   1, 0, 32'h0,        0, 1, 0, 32'h44);
    // three reads, then cyc drop -> drain
    tbl[20] = mk(1, 1, 0, 32'h300, 32'h0,   1, 0, 32'h0,        1, 0, 0, 32'h44);
    tbl[21] = mk(1, 1, 0, 32'h304, 32'h0,   1, 0, 32'h0,        1, 0, 0, 32'h44);
    tbl[22] = mk(1, 1, 0, 32'h308, 32'h0,   1, 0, 32'h0,        1, 0, 0, 32'h44);
    tbl[23] = mk(0, 0, 0, 32'h0,   32'h0,   1, 0, 32'h0,        0, 1, 0, 32'h44);
    tbl[24] = mk(1, 1, 0, 32'h30C, 32'h0,   1, 0, 32'h0,        0, 1, 0, 32'h44);
    tbl[25] = mk(1, 1, 0, 32'h30C, 32'h0,   1, 1, 32'h66,       0, 1, 0, 32'h44);
    tbl[26] = mk(1, 1, 0, 32'h30C, 32'h0,   1, 1, 32'h77,       0, 1, 0, 32'h66);
    tbl[27] = mk(1, 1, 0, 32'h30C, 32'h0,   1, 1, 32'h88,       0, 1, 0, 32'h77);
    tbl[28] = mk(1, 1, 0, 32'h30C, 32'h0,   1, 0, 32'h0,        1, 0, 0, 32'h88);
    tbl[29] = mk(1, 0, 0, 32'h0,   32'h0,   1, 1, 32'h99,       0, 1, 0, 32'h88);
    tbl[30] = mk(0, 0, 0, 32'h0,   32'h0,   1, 0, 32'h0,        0, 1, 1, 32'h99);
    tbl[31] = mk(0, 0, 0, 32'h0,   32'h0,   1, 0, 32'h0,        0, 1, 0, 32'h99);

    // Reset values
    #3;
    chk("rst.ack",   {31'd0, ack},   32'd0);
    chk("rst.dat",   dat_o,          32'd0);
    chk("rst.req",   {31'd0, req},   32'd0);
    chk("rst.stall", {31'd0, stall}, 32'd1);
    chk("rst.err",   {31'd0, wb_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) step(tbl[i], $sformatf("v%0d", i));

    // Async reset with reads outstanding and an ack pending
    step(mk(1, 1, 0, 32'h400, 32'h0, 1, 0, 32'h0,    1, 0, 0, 32'h99), "r0");
    step(mk(1, 1, 0, 32'h404, 32'h0, 1, 0, 32'h0,    1, 0, 0, 32'h99), "r1");
    step(mk(1, 1, 0, 32'h408, 32'h0, 1, 0, 32'h0,    1, 0, 0, 32'h99), "r2");
    step(mk(1, 0, 0, 32'h0,   32'h0, 1, 1, 32'hABCD, 0, 1, 0, 32'h99), "r3");
    step(mk(1, 0, 0, 32'h0,   32'h0, 1, 0, 32'h0,    0, 1, 1, 32'hABCD), "r4");
    #2 rst_n = 1'b0;
    #1;
    chk("arst.ack",   {31'd0, ack},   32'd0);
    chk("arst.dat",   dat_o,          32'd0);
    chk("arst.stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(1, 0, 0, 32'h0,   32'h0,  1, 1, 32'h0, 0, 1, 0, 32'h0), "s0");
    step(mk(1, 0, 0, 32'h0,   32'h0,  1, 1, 32'h0, 0, 1, 0, 32'h0), "s1");
    step(mk(1, 0, 0, 32'h0,   32'h0,  1, 0, 32'h0, 0, 1, 0, 32'h0), "s2");
    // Counter must be zero: exactly four more issues fit
    step(mk(1, 1, 1, 32'h500, 32'hB0, 1, 0, 32'h0, 1, 0, 0, 32'h0), "f0");
    step(mk(1, 1, 1, 32'h504, 32'hB1, 1, 0, 32'h0, 1, 0, 0, 32'h0), "f1");
    step(mk(1, 1, 1, 32'h508, 32'hB2, 1, 0, 32'h0, 1, 0, 0, 32'h0), "f2");
    step(mk(1, 1, 1, 32'h50C, 32'hB3, 1, 0, 32'h0, 1, 0, 0, 32'h0), "f3");
    step(mk(1, 1, 1, 32'h510, 32'hB4, 1, 0, 32'h0, 0, 1, 0, 32'h0), "f4");

`ifdef WB_TO_OBI_ERR_EN
    // Error response at full: err, no ack, and a slot is freed
    v = mk(1, 0, 1, 32'h0, 32'h0, 1, 1, 32'h0, 0, 1, 0, 32'h0);
    v.err = 1'b1;
    step(v, "e0");
    v = mk(1, 0, 1, 32'h0, 32'h0, 1, 0, 32'h0, 0, 1, 0, 32'h0);
    v.exp_err = 1'b1;
    step(v, "e1");
    step(mk(1, 1, 1, 32'h600, 32'hC0, 1, 0, 32'h0, 1, 0, 0, 32'h0), "e2");
`else
    v = mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 32'h0);
    step(v, "idle");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_to_obi_pipe.md
# wb_to_obi_pipe

Parametrised Wishbone-B4-pipelined slave to OBI master bridge, the next-generation Wishbone/OBI bridge for the caravel user area. It issues one OBI request per Wishbone strobe with no stall cycles while the OBI grant is high, and tracks up to MAX_OUT outstanding transactions. Reads and writes both complete only on OBI `rvalid_i`. If the master drops `wbs_cyc_i` mid-burst, the bridge drains the remaining responses safely.

## Interface
- ADDR_W, 32: address width, Wishbone and OBI.
- DATA_W, 32: data width; multiple of 8. SEL_W = DATA_W/8.
- MAX_OUT, 4: maximum outstanding OBI transactions; ≥1. Counter width CNT_W = $clog2(MAX_OUT+1).

- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; one clock; asynchronous, active-low.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  SEL_W  byte select.
- wbs_adr_i  in  ADDR_W  address.
- wbs_dat_i  in  DATA_W  write data.
- wbs_ack_o  out  1  response acknowledge.
- wbs_stall_o  out  1  request not accepted this cycle.
- wbs_dat_o  out  DATA_W  read data.
- wbs_err_o  out  1  error response; present only with WB_TO_OBI_ERR_EN.
- req_o  out  1  OBI request.
- gnt_i  in  1  OBI grant.
- addr_o  out  ADDR_W  OBI address.
- we_o  out  1  OBI write enable.
- be_o  out  SEL_W  OBI byte enable.
- wdata_o  out  DATA_W  OBI write data.
- rvalid_i  in  1  OBI response valid.
- rdata_i  in  DATA_W  OBI read data.
- err_i  in  1  OBI error; present only with WB_TO_OBI_ERR_EN.

## Operation
- **States:** ACTIVE and DRAIN. Reset enters ACTIVE.
- **Issue condition:** can_issue = wbs_cyc_i & wbs_stb_i & (state==ACTIVE) & (cnt < MAX_OUT). The comparison uses the registered cnt.
- **Request outputs:** req_o = can_issue. addr_o, we_o, be_o and wdata_o pass through combinationally from the Wishbone inputs.
- **Stall:** wbs_stall_o = !(can_issue & gnt_i). A Wishbone request is accepted exactly when the OBI handshake occurs.
- **Outstanding counter:**
  - +1 on req_o & gnt_i.
  - −1 on rvalid_i & cnt≠0.
  - Both in the same cycle: cnt holds.
  - rvalid_i with cnt==0 is ignored: no ack, cnt stays 0.
- **Response path:** registered.
  - wbs_ack_o ← rvalid_i & cnt≠0 & state==ACTIVE.
  - wbs_dat_o ← rdata_i when rvalid_i, else holds.
  - Write responses are acked exactly like reads.
- **ACTIVE→DRAIN:** when !wbs_cyc_i and cnt_next≠0.
- **DRAIN behaviour:**
  - req_o=0, wbs_stall_o=1.
  - Responses decrement cnt but produce no ack or err.
  - wbs_cyc_i is ignored.
- **DRAIN→ACTIVE:** when cnt_next==0.
- **Full:** cnt==MAX_OUT forces req_o=0 and stall=1, even if rvalid_i frees a slot in the same cycle. Issue resumes the next cycle.
- **Reset mid-operation:** counter, state and response registers clear immediately. Any OBI responses still in flight after reset are ignored by the cnt==0 rule.

## Timing
- **Reset values:**
  - wbs_ack_o=0, wbs_dat_o=0, wbs_err_o=0.
  - cnt=0, state=ACTIVE.
  - req_o and wbs_stall_o follow their combinational equations (req_o=0 when stb is low).
- **Issue latency:** 0 cycles; strobe to req_o is combinational.
- **Response latency:** ack asserts one cycle after rvalid_i.
- **Minimum round trip:** stb+gnt in cycle 0, rvalid in cycle 1, ack in cycle 2.
- **Throughput:** one transaction per cycle, sustained while gnt_i=1, cnt<MAX_OUT and responses keep pace.
- **Ordering:** responses are returned in issue order, as guaranteed by OBI; the bridge holds no reordering state.

## Configuration
- **WB_TO_OBI_ERR_EN defined:**
  - err_i and wbs_err_o ports exist.
  - A response with err_i=1 registers wbs_err_o=1 and wbs_ack_o=0.
  - The counter still decrements.
  - In DRAIN, error responses are silently absorbed.
- **WB_TO_OBI_ERR_EN undefined:**
  - Neither port exists.
  - Every counted response produces wbs_ack_o.

## Test plan
- **Single read:** gnt_i=1; read adr 0x100 in cycle 0; rvalid_i=1 with rdata 0xDEADBEEF in cycle 1 → req_o=1 and stall=0 in cycle 0; wbs_ack_o=1 with wbs_dat_o=0xDEADBEEF in cycle 2; cnt back to 0.
- **Back-to-back writes with MAX_OUT=4:** 6 writes strobed, gnt_i=1, no rvalid → 4 accepted, stall=1 from the 5th strobe; then rvalid for 1 cycle → one ack, and the 5th write issues one cycle after that rvalid.
- **Simultaneous accept and response at cnt=2:** one grant and one rvalid in the same cycle → cnt remains 2, one ack next cycle.
- **Cyc drop:** 3 reads outstanding, wbs_cyc_i falls → DRAIN; req_o=0 even when stb and cyc are reasserted; 3 rvalids → no acks; ACTIVE in the cycle after the last rvalid.
- **Async reset:** rst_ni low for 2 outstanding reads, asserted between clock edges → ack, dat and cnt are 0 immediately; 2 stray rvalids after release → no ack.
- **Error response (WB_TO_OBI_ERR_EN):** write answered by rvalid_i=1, err_i=1 → wbs_err_o=1 and wbs_ack_o=0 one cycle later; cnt decrements.
